// File: rtl/mmu_xlat_requester_if.sv
// Bundled in-stream, MMU request/response and out-stream signals of the translation requester.
// master = the requester, slave = the environment (producer, MMU and consumer).
interface mmu_xlat_requester_if #(
  parameter int unsigned VLEN   = 64,
  parameter int unsigned PLEN   = 56,
  parameter int unsigned CauseW = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [VLEN-1:0]   in_vaddr;
  logic              in_is_store;

  logic              mmu_req;
  logic [VLEN-1:0]   mmu_vaddr;
  logic              mmu_is_store;
  logic              mmu_valid;
  logic [PLEN-1:0]   mmu_paddr;
  logic              mmu_ex_valid;
  logic [CauseW-1:0] mmu_ex_cause;
  logic [CauseW-1:0] mmu_ex_tval;

  logic              out_valid;
  logic              out_ready;
  logic [PLEN-1:0]   out_paddr;
  logic              out_ex_valid;
  logic [CauseW-1:0] out_ex_cause;
  logic [CauseW-1:0] out_ex_tval;

  modport master (
    input  in_valid, in_vaddr, in_is_store,
    output in_ready,
    output mmu_req, mmu_vaddr, mmu_is_store,
    input  mmu_valid, mmu_paddr, mmu_ex_valid, mmu_ex_cause, mmu_ex_tval,
    output out_valid, out_paddr, out_ex_valid, out_ex_cause, out_ex_tval,
    input  out_ready
  );

  modport slave (
    output in_valid, in_vaddr, in_is_store,
    input  in_ready,
    input  mmu_req, mmu_vaddr, mmu_is_store,
    output mmu_valid, mmu_paddr, mmu_ex_valid, mmu_ex_cause, mmu_ex_tval,
    input  out_valid, out_paddr, out_ex_valid, out_ex_cause, out_ex_tval,
    output out_ready
  );
endinterface

// File: rtl/mmu_xlat_requester.sv
// Single-outstanding address-translation requester: in-stream vaddr -> MMU req -> out-stream result.
// Optional REQ watchdog enabled by defining MMU_REQ_TIMEOUT_EN.
module mmu_xlat_requester #(
  parameter int unsigned VLEN          = 64,
  parameter int unsigned PLEN          = 56,
  parameter int unsigned CauseW        = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 ex_clr_i,
  output logic                 halted_o,
  mmu_xlat_requester_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [PLEN-1:0]   PADDR_ZERO = {PLEN{1'b0}};
  localparam logic [CauseW-1:0] CAUSE_ZERO = {CauseW{1'b0}};
  localparam logic [CauseW-1:0] CAUSE_LOAD_ACCESS  = CauseW'(64'd5);
  localparam logic [CauseW-1:0] CAUSE_STORE_ACCESS = CauseW'(64'd7);

  if ((TimeoutCycles < 32'd1) || (PLEN > VLEN)) begin : g_param_check
    $error("mmu_xlat_requester: need TimeoutCycles >= 1 and PLEN <= VLEN");
  end

  function automatic logic [PLEN-1:0] bypass_paddr(input logic [VLEN-1:0] vaddr);
    return vaddr[PLEN-1:0];
  endfunction

  state_e            state_r;
  state_e            state_s;
  logic [VLEN-1:0]   vaddr_r;
  logic              is_store_r;
  logic [PLEN-1:0]   paddr_r;
  logic              ex_valid_r;
  logic [CauseW-1:0] cause_r;
  logic [CauseW-1:0] tval_r;

  logic              accept_s;
  logic              abort_s;
  logic              mmu_hit_s;
  logic              timeout_s;

`ifdef MMU_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TimeoutCycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TimeoutCycles - 1);

  logic [CNT_W-1:0] req_cnt_r;

  // Watchdog: counts REQ cycles, cleared whenever the FSM is outside REQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      req_cnt_r <= req_cnt_r + CNT_W'(1);
    end else begin
      req_cnt_r <= {CNT_W{1'b0}};
    end
  end
`endif

  // Event decode; an en_i drop in REQ takes priority over a same-cycle MMU answer.
  always_comb begin
    accept_s  = 1'b0;
    abort_s   = 1'b0;
    mmu_hit_s = 1'b0;
    timeout_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = bus.in_valid;
    end else if (state_r == ST_REQ) begin
      abort_s   = ~en_i;
      mmu_hit_s = en_i & bus.mmu_valid;
`ifdef MMU_REQ_TIMEOUT_EN
      timeout_s = en_i & ~bus.mmu_valid & (req_cnt_r == CNT_LAST);
`else
      timeout_s = 1'b0;
`endif
    end else begin
      accept_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && en_i) begin
          state_s = ST_REQ;
        end else if (accept_s) begin
          state_s = ST_RSP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (abort_s || mmu_hit_s || timeout_s) begin
          state_s = ST_RSP;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (bus.out_ready && ex_valid_r) begin
          state_s = ST_HALT;
        end else if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RSP;
        end
      end
      ST_HALT: begin
        if (ex_clr_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Request and result registers; the bypass result is preloaded at accept and
  // overwritten by whichever REQ event ends the translation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vaddr_r    <= {VLEN{1'b0}};
      is_store_r <= 1'b0;
      paddr_r    <= PADDR_ZERO;
      ex_valid_r <= 1'b0;
      cause_r    <= CAUSE_ZERO;
      tval_r     <= CAUSE_ZERO;
    end else if (accept_s) begin
      vaddr_r    <= bus.in_vaddr;
      is_store_r <= bus.in_is_store;
      paddr_r    <= bypass_paddr(bus.in_vaddr);
      ex_valid_r <= 1'b0;
      cause_r    <= CAUSE_ZERO;
      tval_r     <= CAUSE_ZERO;
    end else if (abort_s) begin
      paddr_r    <= bypass_paddr(vaddr_r);
      ex_valid_r <= 1'b0;
      cause_r    <= CAUSE_ZERO;
      tval_r     <= CAUSE_ZERO;
    end else if (mmu_hit_s) begin
      paddr_r    <= bus.mmu_ex_valid ? PADDR_ZERO : bus.mmu_paddr;
      ex_valid_r <= bus.mmu_ex_valid;
      cause_r    <= bus.mmu_ex_valid ? bus.mmu_ex_cause : CAUSE_ZERO;
      tval_r     <= bus.mmu_ex_valid ? bus.mmu_ex_tval : CAUSE_ZERO;
    end else if (timeout_s) begin
      paddr_r    <= PADDR_ZERO;
      ex_valid_r <= 1'b1;
      cause_r    <= is_store_r ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
      tval_r     <= CauseW'(vaddr_r);
    end
  end

  // Outputs decoded from the state register and driven straight from registers.
  always_comb begin
    bus.in_ready     = (state_r == ST_IDLE);
    bus.mmu_req      = (state_r == ST_REQ);
    bus.mmu_vaddr    = vaddr_r;
    bus.mmu_is_store = is_store_r;
    bus.out_valid    = (state_r == ST_RSP);
    bus.out_paddr    = paddr_r;
    bus.out_ex_valid = ex_valid_r;
    bus.out_ex_cause = cause_r;
    bus.out_ex_tval  = tval_r;
    halted_o         = (state_r == ST_HALT);
  end

endmodule

// File: tb/tb_mmu_xlat_requester.sv
// Scoreboard bench for mmu_xlat_requester: expected results are queued at accept and
// checked by an independent out-stream monitor; protocol timing is checked by the driver.
module tb_mmu_xlat_requester;

  localparam int unsigned VLEN = 64;
  localparam int unsigned PLEN = 56;
  localparam int unsigned CW   = 64;
  localparam int          TO   = 16;

  typedef struct {
    logic [PLEN-1:0] paddr;
    logic            ex;
    logic [CW-1:0]   cause;
    logic [CW-1:0]   tval;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic en     = 1'b0;
  logic ex_clr = 1'b0;
  logic halted;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mmu_xlat_requester_if #(.VLEN(VLEN), .PLEN(PLEN), .CauseW(CW)) bus ();

  mmu_xlat_requester #(
    .VLEN(VLEN), .PLEN(PLEN), .CauseW(CW), .TimeoutCycles(TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .ex_clr_i (ex_clr),
    .halted_o (halted),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference model: result of one translation from the architectural rules.
  function automatic exp_t model(input bit en_v, input logic [63:0] va, input bit st,
                                 input bit abort, input bit timed_out, input bit mex,
                                 input logic [PLEN-1:0] mpa, input logic [CW-1:0] mc,
                                 input logic [CW-1:0] mt);
    exp_t e;
    e.paddr = '0; e.ex = 1'b0; e.cause = '0; e.tval = '0;
    if (!en_v || abort) begin
      e.paddr = va[PLEN-1:0];
    end else if (timed_out) begin
      e.ex    = 1'b1;
      e.cause = st ? 64'd7 : 64'd5;
      e.tval  = va;
    end else if (mex) begin
      e.ex    = 1'b1;
      e.cause = mc;
      e.tval  = mt;
    end else begin
      e.paddr = mpa;
    end
    return e;
  endfunction

  // Monitor: every out-stream handshake pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_paddr", 64'(bus.out_paddr), 64'(e.paddr));
        chk("out_ex_valid", 64'(bus.out_ex_valid), 64'(e.ex));
        chk("out_ex_cause", bus.out_ex_cause, e.cause);
        chk("out_ex_tval", bus.out_ex_tval, e.tval);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; lat = REQ cycle in which the MMU answers (or en drops if abort).
  task automatic do_txn(input bit en_v, input logic [63:0] va, input bit st, input int lat,
                        input bit abort, input bit mex, input logic [PLEN-1:0] mpa,
                        input logic [CW-1:0] mc, input logic [CW-1:0] mt, input int stall);
    int   w;
    int   n;
    bit   timed_out;
    exp_t e;
    logic [63:0] r;
    timed_out = 1'b0;
`ifdef MMU_REQ_TIMEOUT_EN
    timed_out = en_v && !abort && (lat > TO);
`endif
    w = 0;
    en = en_v;
    while (!bus.in_ready && w < 50) begin
      cyc();
      w++;
    end
    if (!bus.in_ready) begin
      chk("accept_wait_expired", 64'd0, 64'd1);
      return;
    end
    bus.in_valid    = 1'b1;
    bus.in_vaddr    = va;
    bus.in_is_store = st;
    e = model(en_v, va, st, abort, timed_out, mex, mpa, mc, mt);
    exp_q.push_back(e);
    cyc();
    bus.in_valid = 1'b0;
    if (en_v) begin
      n = timed_out ? TO : lat;
      for (int i = 1; i <= n; i++) begin
        chk("mmu_req_high", 64'(bus.mmu_req), 64'd1);
        chk("mmu_vaddr", bus.mmu_vaddr, va);
        chk("mmu_is_store", 64'(bus.mmu_is_store), 64'(st));
        chk("out_valid_low_in_req", 64'(bus.out_valid), 64'd0);
        if (i == n && !timed_out) begin
          if (abort) begin
            en = 1'b0;
          end else begin
            bus.mmu_valid    = 1'b1;
            bus.mmu_paddr    = mpa;
            bus.mmu_ex_valid = mex;
            bus.mmu_ex_cause = mc;
            bus.mmu_ex_tval  = mt;
          end
        end
        cyc();
      end
      bus.mmu_valid = timed_out;
    end
    chk("mmu_req_low_after", 64'(bus.mmu_req), 64'd0);
    chk("out_valid_rise", 64'(bus.out_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_mmu_req", 64'(bus.mmu_req), 64'd0);
      r = {$urandom, $urandom};
      bus.mmu_valid    = (s == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.mmu_paddr    = r[PLEN-1:0];
      bus.mmu_ex_valid = ~mex;
      bus.mmu_ex_cause = r;
      bus.mmu_ex_tval  = ~r;
      cyc();
    end
    bus.mmu_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    if (e.ex) begin
      for (int h = 0; h < 3; h++) begin
        chk("halted_high", 64'(halted), 64'd1);
        chk("halt_in_ready", 64'(bus.in_ready), 64'd0);
        cyc();
      end
      ex_clr = 1'b1;
      cyc();
      ex_clr = 1'b0;
      chk("in_ready_after_clr", 64'(bus.in_ready), 64'd1);
      chk("halted_cleared", 64'(halted), 64'd0);
    end else begin
      chk("in_ready_after_rsp", 64'(bus.in_ready), 64'd1);
      chk("halted_low", 64'(halted), 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] va;
    logic [63:0] r1;
    logic [63:0] r2;
    bus.in_valid = 1'b0; bus.in_vaddr = '0; bus.in_is_store = 1'b0;
    bus.mmu_valid = 1'b0; bus.mmu_paddr = '0; bus.mmu_ex_valid = 1'b0;
    bus.mmu_ex_cause = '0; bus.mmu_ex_tval = '0; bus.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_paddr", 64'(bus.out_paddr), 64'd0);
    chk("rst_out_ex_valid", 64'(bus.out_ex_valid), 64'd0);
    chk("rst_out_ex_cause", bus.out_ex_cause, 64'd0);
    chk("rst_out_ex_tval", bus.out_ex_tval, 64'd0);
    chk("rst_mmu_req", 64'(bus.mmu_req), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    cyc();

    do_txn(1'b1, 64'h8000_1000, 1'b0, 3, 1'b0, 1'b0, 56'h80_0010_00, 64'd0, 64'd0, 0);
    do_txn(1'b1, 64'h4000, 1'b1, 2, 1'b0, 1'b1, 56'h12_3456, 64'd15, 64'h4000, 1);
    do_txn(1'b0, 64'hFFFF_FFFF_0000_1234, 1'b0, 1, 1'b0, 1'b0, 56'd0, 64'd0, 64'd0, 0);
    do_txn(1'b1, 64'h0000_1234_5678_9ABC, 1'b1, 1, 1'b0, 1'b0, 56'hAB_CDEF_0123_4567,
           64'd0, 64'd0, 10);
    do_txn(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 3, 1'b1, 1'b0, 56'h11_2233, 64'd0, 64'd0, 2);
    do_txn(1'b1, 64'h0000_00AB_CDEF_0000, 1'b0, 1000, 1'b0, 1'b0, 56'h55_6677_8899,
           64'd0, 64'd0, 3);

    // Reset during REQ discards the request without producing a result.
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vaddr = 64'h7777_0000;
    cyc();
    bus.in_valid = 1'b0;
    chk("pre_reset_mmu_req", 64'(bus.mmu_req), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("reset_mid_mmu_req", 64'(bus.mmu_req), 64'd0);
    chk("reset_mid_in_ready", 64'(bus.in_ready), 64'd1);
    bus.mmu_valid = 1'b1;
    cyc();
    bus.mmu_valid = 1'b0;
    chk("ignored_mmu_valid", 64'(bus.out_valid), 64'd0);

    for (int t = 0; t < 60; t++) begin
      va = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      do_txn(1'($urandom_range(0, 3) != 0), va, 1'($urandom_range(0, 1)),
             $urandom_range(1, 8), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 5) == 0), r1[PLEN-1:0], r2, ~r1,
             $urandom_range(0, 4));
    end

    repeat (3) cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
